// File: rtl/aes_pkg.sv
// AES inverse-cipher shared definitions.
//
// Contents:
//   aes_state_t       128-bit block as 16 bytes; byte 4*c+r is row r of
//                     column c (FIPS-197 column-major input order).
//   NR_128/192/256    round counts for the three key sizes.
//   INV_SBOX          inverse S-box lookup table.
//   xtime, gmul       GF(2^8) arithmetic, reduction polynomial 0x11B.
//   inv_shift_rows    row r rotated right by r positions.
//   inv_sub_bytes     INV_SBOX applied to every byte.
//   inv_mix_columns   column transform with coefficients 0e/0b/0d/09.
package aes_pkg;

    typedef logic [15:0][7:0] aes_state_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b the unused terms fold away.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[4'(4 * c + rw)] = s[4'(4 * ((c - rw + 4) % 4) + rw)];
            end
        end
        return r;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t r;
        for (int i = 0; i < 16; i++) begin
            r[4'(i)] = INV_SBOX[s[4'(i)]];
        end
        return r;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(4 * c)];
            a1 = s[4'(4 * c + 1)];
            a2 = s[4'(4 * c + 2)];
            a3 = s[4'(4 * c + 3)];
            r[4'(4 * c)]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[4'(4 * c + 1)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[4'(4 * c + 2)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[4'(4 * c + 3)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_core.sv
// One combinational AES inverse round (standard inverse-cipher order).
//
// Ports:
//   state       current 128-bit state
//   rk          round key for this round, untransformed KeyExpansion words
//   last        1 = final round, InvMixColumns is skipped
//   next_state  InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk),
//               or without InvMixColumns when last=1
module aes_inv_round_core
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       last,
    output aes_state_t next_state
);

    aes_state_t keyed;

    assign keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    assign next_state = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, NR+1 cycles
// from accept to result, AES-128/192/256 selected by NR.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     ciphertext handshake; in_ready only in IDLE
//   in_data               ciphertext, byte 0 = first FIPS-197 byte
//   rk_idx/rk             round-key read port into an external schedule;
//                         rk must be the combinational read of rk_idx
//   out_valid/out_ready   plaintext handshake; data held until taken
//   out_data              plaintext (state register)
//   busy                  a block is in flight or waiting to be taken
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter  int NR    = 10,
    localparam int RK_AW = $clog2(NR + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0][7:0]       in_data,
    output logic [RK_AW-1:0]       rk_idx,
    input  logic [15:0][7:0]       rk,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0][7:0]       out_data,
    output logic                   busy
);

    if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [RK_AW-1:0] CNT_TOP   = RK_AW'(NR);
    localparam logic [RK_AW-1:0] CNT_FIRST = RK_AW'(NR - 1);
    localparam logic [RK_AW-1:0] CNT_ONE   = RK_AW'(1);

    logic [1:0]       fsm;
    logic [RK_AW-1:0] cnt;
    aes_state_t       state_reg;
    aes_state_t       round_out;

    // cnt doubles as the round-key index: it rests at NR in IDLE (initial
    // AddRoundKey), walks NR-1..1 in ROUND and reaches 0 for FINAL, so
    // rk_idx comes straight from a register.
    assign rk_idx    = cnt;
    assign in_ready  = (fsm == ST_IDLE) && !reset;
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm != ST_IDLE);
    assign out_data  = state_reg;

    aes_inv_round_core u_round (
        .state      (state_reg),
        .rk         (rk),
        .last       (fsm == ST_FINAL),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= ST_IDLE;
            cnt       <= CNT_TOP;
            state_reg <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ rk;
                        cnt       <= CNT_FIRST;
                        fsm       <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_ONE) fsm <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_reg <= round_out;
                    cnt       <= CNT_TOP;
                    fsm       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) fsm <= ST_IDLE;
                end
                default: begin
                    fsm <= ST_IDLE;
                    cnt <= CNT_TOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: three instances (NR=10/12/14) fed
// by a bench-built key schedule, checked against FIPS-197 known answers.
module tb_aes_inv_cipher_iter;

    typedef logic [15:0][7:0] blk_t;

    localparam int NRS [3] = '{10, 12, 14};
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid  [3];
    logic       in_ready  [3];
    blk_t       in_data   [3];
    logic [3:0] rk_idx    [3];
    blk_t       rk        [3];
    logic       out_valid [3];
    logic       out_ready [3];
    blk_t       out_data  [3];
    logic       busy      [3];

    blk_t       sched [3][16];
    logic [7:0] sbox_tb [256];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_cipher_iter #(.NR(10 + 2 * g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .rk_idx    (rk_idx[g]),
            .rk        (rk[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
        assign rk[g] = sched[g][rk_idx[g]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // First hex byte of a FIPS-197 string becomes byte 0.
    function automatic blk_t bytes_of(input logic [127:0] h);
        blk_t r;
        for (int i = 0; i < 16; i++) r[i] = h[127 - 8 * i -: 8];
        return r;
    endfunction

    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, acc;
        x = a; y = b; acc = 8'h00;
        while (y != 8'h00) begin
            if (y[0]) acc = acc ^ x;
            x = tb_xtime(x);
            y = y >> 1;
        end
        return acc;
    endfunction

    // Forward S-box from its definition: GF inverse, then affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (tb_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tb[a] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
    endfunction

    // KeyExpansion for key bytes 00,01,02,... of length 4*(nr-6).
    task automatic expand(input int g, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) sched[g][r] = '0;
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    sched[g][r][4 * c + b] = w[4 * r + c][31 - 8 * b -: 8];
    endtask

    task automatic wait_out(input int g, output int n);
        n = 0;
        while (!out_valid[g] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Offer one block with out_ready high, follow rk_idx each cycle and
    // count edges from the accept edge until out_valid.
    task automatic run_block(input int g, input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int lat, exp_idx;
        bit seq_ok;
        check({tag, " in_ready idle"}, 128'(in_ready[g]), 128'd1);
        in_data[g] = bytes_of(ct); in_valid[g] = 1'b1; out_ready[g] = 1'b1;
        seq_ok = 1'b1; exp_idx = NRS[g]; lat = 0;
        while (!out_valid[g] && lat < 40) begin
            if (int'(rk_idx[g]) != exp_idx) seq_ok = 1'b0;
            @(posedge clk); #1;
            in_valid[g] = 1'b0;
            lat++; exp_idx--;
        end
        check({tag, " latency"}, 128'(lat), 128'(NRS[g] + 1));
        check({tag, " rk_idx sequence"}, 128'(seq_ok), 128'd1);
        check({tag, " out_data"}, out_data[g], bytes_of(pt));
        @(posedge clk); #1;
        check({tag, " out_valid drop"}, 128'(out_valid[g]), 128'd0);
        check({tag, " in_ready after"}, 128'(in_ready[g]), 128'd1);
    endtask

    typedef struct {
        int           g;
        logic [127:0] ct;
        logic [127:0] pt;
        string        tag;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int   n, acc, outs, cyc;
        int   acc_t [3];
        bit   hold_ok, ign_ok;

        vecs[0] = '{0, CT128, PT, "kat128"};
        vecs[1] = '{1, CT192, PT, "kat192"};
        vecs[2] = '{2, CT256, PT, "kat256"};

        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
        end
        build_sbox();
        expand(0, 10);
        expand(1, 12);
        expand(2, 14);

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst in_ready%0d", g), 128'(in_ready[g]), 128'd0);
            check($sformatf("rst out_valid%0d", g), 128'(out_valid[g]), 128'd0);
            check($sformatf("rst busy%0d", g), 128'(busy[g]), 128'd0);
            check($sformatf("rst rk_idx%0d", g), 128'(rk_idx[g]), 128'(NRS[g]));
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors for all three key sizes.
        for (int i = 0; i < 3; i++) run_block(vecs[i].g, vecs[i].ct, vecs[i].pt, vecs[i].tag);

        // Backpressure: result held for 5 cycles with out_ready low.
        in_data[0] = bytes_of(CT128); in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_out(0, n);
        check("bp latency", 128'(n), 128'd10);
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (out_data[0] !== bytes_of(PT) || in_ready[0] !== 1'b0 ||
                busy[0] !== 1'b1 || out_valid[0] !== 1'b1) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("bp hold", 128'(hold_ok), 128'd1);
        check("bp out_data", out_data[0], bytes_of(PT));
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", 128'(out_valid[0]), 128'd0);
        check("bp release in_ready", 128'(in_ready[0]), 128'd1);
        check("bp release busy", 128'(busy[0]), 128'd0);

        // Reset in the middle of a block.
        in_data[0] = bytes_of(CT128); in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst rk_idx round5", 128'(rk_idx[0]), 128'd5);
        reset = 1'b1;
        #1;
        check("midrst in_ready during", 128'(in_ready[0]), 128'd0);
        @(posedge clk); #1;
        check("midrst out_valid", 128'(out_valid[0]), 128'd0);
        check("midrst busy", 128'(busy[0]), 128'd0);
        check("midrst rk_idx", 128'(rk_idx[0]), 128'd10);
        reset = 1'b0;
        #1;
        check("midrst in_ready after", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        run_block(0, CT128, PT, "post_rst");

        // in_valid wiggled with junk during ROUND; a real block held from
        // the last ROUND cycle must only be taken once back in IDLE.
        in_data[0] = bytes_of(CT128); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        ign_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid[0] = k[0];
            in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (in_ready[0] !== 1'b0) ign_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("ign in_ready low", 128'(ign_ok), 128'd1);
        in_data[0] = bytes_of(CT128); in_valid[0] = 1'b1;
        wait_out(0, n);
        check("ign first latency", 128'(n), 128'd2);
        check("ign first out_data", out_data[0], bytes_of(PT));
        @(posedge clk); #1;
        check("ign not taken in DONE", 128'(busy[0]), 128'd0);
        check("ign idle in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("ign second accepted", 128'(busy[0]), 128'd1);
        wait_out(0, n);
        check("ign second latency", 128'(n), 128'd10);
        check("ign second out_data", out_data[0], bytes_of(PT));
        @(posedge clk); #1;

        // NR=12 streaming with in_valid and out_ready held high.
        in_data[1] = bytes_of(CT192); in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        acc = 0; outs = 0; cyc = 0;
        acc_t = '{0, 0, 0};
        while ((acc < 3 || outs < 3) && cyc < 120) begin
            if (acc == 3) in_valid[1] = 1'b0;
            #1;
            if (out_valid[1]) begin
                check($sformatf("stream out_data%0d", outs), out_data[1], bytes_of(PT));
                outs++;
            end
            if (in_valid[1] && in_ready[1] && acc < 3) begin
                acc_t[acc] = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid[1] = 1'b0;
        check("stream accepts", 128'(acc), 128'd3);
        check("stream outputs", 128'(outs), 128'd3);
        check("stream spacing 1", 128'(acc_t[1] - acc_t[0]), 128'd14);
        check("stream spacing 2", 128'(acc_t[2] - acc_t[1]), 128'd14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher: decrypts one 128-bit block in NR+1 clock cycles, reusing one combinational inverse-round datapath per cycle. Generalises the single inverse round to AES-128/192/256 via NR. It adds a final round without InvMixColumns, a valid/ready handshake on both sides, and a round-key read port into an externally built key-schedule store.

Parameters:
NR, 10, number of rounds; legal values 10/12/14; any other value is an elaboration error.
RK_AW, $clog2(NR+1), round-key index width (derived; never overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  ciphertext block offered
in_ready  out  1  block accepted when in_valid & in_ready
in_data  in  [15:0][7:0]  ciphertext; byte 0 = FIPS-197 byte in0 (column-major)
rk_idx  out  RK_AW  round-key index requested this cycle
rk  in  [15:0][7:0]  round key rk[rk_idx], combinational read, valid same cycle
out_valid  out  1  plaintext available
out_ready  in  1  consumer takes block when out_valid & out_ready
out_data  out  [15:0][7:0]  plaintext, same byte order as in_data
busy  out  1  high in LOAD-after-accept through DONE

Behaviour:
- One clock, clk. Reset is synchronous and active-high: on a rising edge with reset=1 the FSM goes to IDLE, round counter = NR, state register = 0, out_valid=0, busy=0. in_ready=0 during the reset cycle. Reset mid-block aborts the block with no output.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1, rk_idx=NR. On in_valid: state <= in_data ^ rk (AddRoundKey rk[NR]); cnt <= NR-1; go to ROUND if NR-1>=1 (always true for legal NR).
- ROUND (cnt = NR-1 down to 1): rk_idx=cnt; state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk)); cnt <= cnt-1. When cnt==1, go to FINAL next.
- FINAL: rk_idx=0; state <= InvSubBytes(InvShiftRows(state)) ^ rk (no InvMixColumns); go to DONE.
- DONE: out_valid=1, out_data=state, held stable until out_ready; on handshake go to IDLE, out_valid=0.
- in_ready=1 only in IDLE, so there is no overlap and no back-to-back within DONE. Minimum block period is NR+2 cycles with out_ready tied high.
- Latency: accept edge at cycle 0 -> out_valid rises after cycle NR+1 (edge NR+1); NR=10 gives 11 cycles.
- rk_idx is driven from the FSM state/counter registers only (no combinational path from in_valid or out_ready). It is stable for the whole cycle.
- out_data = state register at all times; it is only meaningful while out_valid=1.
- Ordering is the standard (not equivalent) inverse cipher: round keys are FIPS-197 KeyExpansion words, untransformed.
- Arithmetic: GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0e,0b,0d,09.
- in_valid while not in IDLE is ignored; the source must hold it.
- out_ready while out_valid=0 has no effect.

Decomposition:
- aes_pkg holds:
  - typedef aes_state_t = logic [15:0][7:0]
  - INV_SBOX constant array [256]
  - functions xtime, gmul, inv_shift_rows, inv_mix_columns
  - localparam NR_128/192/256 = 10/12/14
- One sub-module, aes_inv_round_core (combinational): inputs state, rk, last; output next_state. It applies InvShiftRows -> InvSubBytes -> AddRoundKey, then InvMixColumns unless last=1.
- The top level holds the FSM, counter, state register and handshakes.

Test Plan:
1. NR=10, key 000102..0f schedule loaded, in_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> rk_idx sequence 10,9..0; out_data 00112233445566778899aabbccddeeff; out_valid at edge 11 after accept.
2. NR=14, key 000102..1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff after 15 cycles.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle, in_ready=1.
4. Reset asserted at round 5 of a block -> next cycle out_valid=0, busy=0, in_ready=1 after reset drops; a following block decrypts correctly.
5. in_valid toggled during ROUND with a different block -> ignored; first block's result unchanged; second block is accepted only in IDLE.
6. NR=12, key 000102..17, in_data dda97ca4864cdfe06eaf70a0ec0d7191, 3 blocks streamed with out_ready=1 -> all decrypt to 00112233..eeff; accept spacing of 14 cycles.
